// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizing for the RAM access controller.
package ram_ctrl_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 6;
  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT      = 64;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    READ_WAIT,
    RSP_HOLD
  } state_e;

endpackage

// File: rtl/ram_rr_arb.sv
// Two-way round-robin arbiter between write and read requests.
module ram_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_req_i,
  input  logic rd_req_i,
  output logic wr_gnt_o,
  output logic rd_gnt_o
);

  logic rdPrio_q;
  logic rdPrio_d;
  logic collision;

  // Priority only moves when both sides actually competed.
  always_comb begin
    collision = wr_req_i && rd_req_i;
    wr_gnt_o  = wr_req_i && (!rd_req_i || !rdPrio_q);
    rd_gnt_o  = rd_req_i && (!wr_req_i || rdPrio_q);
    rdPrio_d  = collision ? !rdPrio_q : rdPrio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPrio_q <= 1'b0;
    end else begin
      rdPrio_q <= rdPrio_d;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Front-end for an external single-port RAM: clears it after reset, then
// arbitrates write/read requests and returns read data with a held response.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int addr_width = ADDR_WIDTH_DEFAULT,
  parameter int data_width = DATA_WIDTH_DEFAULT,
  parameter int depth      = DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [addr_width-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_data,
  output logic [data_width-1:0] ram_data,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [data_width-1:0] ram_q,
  output logic                  init_done
);

  localparam logic [addr_width-1:0] LastAddr = addr_width'(depth - 1);

  state_e                state_q, state_d;
  logic [addr_width-1:0] initCnt_q, initCnt_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  rspValid_q, rspValid_d;
  logic [data_width-1:0] rspData_q, rspData_d;
  logic                  initDone_q, initDone_d;

  logic wrReady;
  logic rdReady;
  logic wrReq;
  logic rdReq;
  logic wrGnt;
  logic rdGnt;
  logic ramWe;

  // Readies depend only on the registered state, keeping the grant path loop-free.
  assign wrReady = (state_q == IDLE) || (state_q == RSP_HOLD);
  assign rdReady = (state_q == IDLE);
  assign wrReq   = wr_valid && wrReady;
  assign rdReq   = rd_valid && rdReady;

  ram_rr_arb u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_req_i (wrReq),
    .rd_req_i (rdReq),
    .wr_gnt_o (wrGnt),
    .rd_gnt_o (rdGnt)
  );

  always_comb begin
    state_d    = state_q;
    initCnt_d  = initCnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    initDone_d = initDone_q;
    ramWe      = 1'b0;

    if (wrGnt) begin
      ramWe  = 1'b1;
      addr_d = wr_addr;
      data_d = wr_data;
    end

    unique case (state_q)
      INIT: begin
        ramWe  = 1'b1;
        addr_d = initCnt_q;
        data_d = '0;
        if (initCnt_q == LastAddr) begin
          state_d    = IDLE;
          initDone_d = 1'b1;
        end else begin
          initCnt_d = initCnt_q + addr_width'(1);
        end
      end
      IDLE: begin
        if (rdGnt) begin
          addr_d  = rd_addr;
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        rspData_d  = ram_q;
        rspValid_d = 1'b1;
        state_d    = RSP_HOLD;
      end
      RSP_HOLD: begin
        if (rspValid_q && rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      initCnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      initDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      initCnt_q  <= initCnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      initDone_q <= initDone_d;
    end
  end

  // RAM port is driven straight from next-state so a grant reaches the RAM this cycle.
  assign ram_we    = ramWe;
  assign ram_addr  = addr_d;
  assign ram_data  = data_d;
  assign wr_ready  = wrReady;
  assign rd_ready  = rdReady;
  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign init_done = initDone_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench: external RAM model plus a transaction-level reference
// (memory array and round-robin priority bit) for the RAM access controller.
module tb_ram_access_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [5:0] rd_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_q;
  logic       init_done;

  logic [7:0] ramMem [64];
  logic [7:0] refMem [64];
  bit         prioRd;
  int         nCompared;
  int         nMismatch;

  ram_access_ctrl #(.addr_width(6), .data_width(8), .depth(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_addr] <= ram_data;
    else        ram_q <= ramMem[ram_addr];
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 64; i++) refMem[i] = 8'h00;
    prioRd = 1'b0;
  endtask

  // Counts rising edges from reset release until init_done is seen.
  task automatic waitInit();
    int n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
      #2;
    end
    checkOutput("init_latency", 32'(n), 32'd64);
    checkOutput("init_wr_ready", 32'(wr_ready), 32'd1);
  endtask

  // One IDLE-state request cycle, plus the full response phase if a read is granted.
  task automatic applyStimulus(input bit wv, input logic [5:0] wa, input logic [7:0] wd,
                               input bit rv, input logic [5:0] ra, input int stall,
                               input bit holdWr, input logic [5:0] ha, input logic [7:0] hd);
    bit         expWr;
    bit         expRd;
    logic [7:0] expData;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    #1;
    expWr = wv && !(rv && prioRd);
    expRd = rv && !(wv && !prioRd);
    if (wv && rv) prioRd = !prioRd;
    checkOutput("idle_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("idle_rd_ready", 32'(rd_ready), 32'd1);
    checkOutput("grant_ram_we", 32'(ram_we), 32'(expWr));
    if (expWr || expRd) checkOutput("grant_ram_addr", 32'(ram_addr), 32'(expWr ? wa : ra));
    if (expWr) checkOutput("grant_ram_data", 32'(ram_data), 32'(wd));
    expData = refMem[ra];
    @(posedge clk);
    #2;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    if (expWr) refMem[wa] = wd;
    if (expRd) begin
      #1;
      checkOutput("rdwait_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rdwait_rd_ready", 32'(rd_ready), 32'd0);
      checkOutput("rdwait_wr_ready", 32'(wr_ready), 32'd0);
      @(posedge clk);
      #2;
      checkOutput("rsp_latency", 32'(rsp_valid), 32'd1);
      checkOutput("rsp_data", 32'(rsp_data), 32'(expData));
      for (int i = 0; i < stall; i++) begin
        if (holdWr && i == 0) begin
          wr_valid = 1'b1; wr_addr = ha; wr_data = hd;
        end
        #1;
        checkOutput("hold_rd_ready", 32'(rd_ready), 32'd0);
        checkOutput("hold_wr_ready", 32'(wr_ready), 32'd1);
        checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("hold_rsp_data", 32'(rsp_data), 32'(expData));
        if (holdWr && i == 0) checkOutput("hold_ram_we", 32'(ram_we), 32'd1);
        @(posedge clk);
        #2;
        if (holdWr && i == 0) begin
          wr_valid = 1'b0;
          refMem[ha] = hd;
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #2;
      rsp_ready = 1'b0;
      #1;
      checkOutput("rsp_clear", 32'(rsp_valid), 32'd0);
      checkOutput("back_idle_rd_ready", 32'(rd_ready), 32'd1);
    end
  endtask

  initial begin
    bit         wv;
    bit         rv;
    logic [5:0] ra;
    logic [5:0] wa;
    logic [7:0] wd;
    int         n;
    nCompared = 0;
    nMismatch = 0;
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b0;
    clearModel();

    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_init_done", 32'(init_done), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_rd_ready", 32'(rd_ready), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_ram_we", 32'(ram_we), 32'd1);
    rst_n = 1'b1;
    waitInit();

    // First collision goes to the write, the next one to the read.
    applyStimulus(1'b1, 6'd5, 8'h3C, 1'b1, 6'd5, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd5, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b1, 6'd6, 8'h77, 1'b1, 6'd5, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b1, 6'd8, 8'h12, 1'b1, 6'd6, 0, 1'b0, 6'd0, 8'h00);

    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd40, 0, 1'b0, 6'd0, 8'h00);

    applyStimulus(1'b1, 6'd10, 8'hAA, 1'b0, 6'd0, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b1, 6'd20, 8'h55, 1'b0, 6'd0, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b1, 6'd30, 8'hFF, 1'b0, 6'd0, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd10, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd20, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd30, 0, 1'b0, 6'd0, 8'h00);

    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd10, 5, 1'b1, 6'd7, 8'h99);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd7, 0, 1'b0, 6'd0, 8'h00);

    applyStimulus(1'b1, 6'd63, 8'h81, 1'b0, 6'd0, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd63, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd0, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd62, 0, 1'b0, 6'd0, 8'h00);

    for (int k = 0; k < 40; k++) begin
      n  = int'($urandom_range(0, 2));
      wv = (n != 1);
      rv = (n != 0);
      wa = 6'($urandom_range(0, 63));
      wd = 8'($urandom);
      ra = 6'($urandom_range(0, 63));
      applyStimulus(wv, wa, wd, rv, ra, int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom));
    end

    // Reset in the middle of the clear.
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    clearModel();
    n = 0;
    while (ram_addr !== 6'd20 && n < 100) begin
      @(posedge clk);
      n++;
      #2;
    end
    checkOutput("init_reach_20", 32'(n), 32'd20);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_init_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("abort_init_done", 32'(init_done), 32'd0);
    checkOutput("abort_init_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    waitInit();

    // Reset while a read is in flight must drop the response.
    applyStimulus(1'b1, 6'd9, 8'h5A, 1'b0, 6'd0, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd9, 0, 1'b0, 6'd0, 8'h00);
    rd_valid = 1'b1;
    rd_addr  = 6'd9;
    @(posedge clk);
    #2;
    rd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_rd_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("abort_rd_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("abort_rd_rd_ready", 32'(rd_ready), 32'd0);
    checkOutput("abort_rd_ram_addr", 32'(ram_addr), 32'd0);
    @(posedge clk);
    #2;
    checkOutput("abort_rd_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    clearModel();
    waitInit();
    checkOutput("post_reset_no_rsp", 32'(rsp_valid), 32'd0);

    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd9, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b1, 6'd11, 8'hC3, 1'b1, 6'd11, 0, 1'b0, 6'd0, 8'h00);
    applyStimulus(1'b0, 6'd0, 8'h00, 1'b1, 6'd11, 1, 1'b0, 6'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 The block SHALL have the parameter addr_width, default 6, which sets the RAM address width.
REQ-002 The block SHALL have the parameter data_width, default 8, which sets the RAM word width.
REQ-003 The block SHALL have the parameter depth, default 64, which sets the number of RAM words.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have the write request ports wr_valid (input, 1), wr_ready (output, 1), wr_addr (input, addr_width) and wr_data (input, data_width).
REQ-007 The block SHALL have the read request ports rd_valid (input, 1), rd_ready (output, 1) and rd_addr (input, addr_width).
REQ-008 The block SHALL have the read response ports rsp_valid (output, 1), rsp_ready (input, 1) and rsp_data (output, data_width).
REQ-009 The block SHALL drive the single_port_ram through ram_data (output, data_width), ram_addr (output, addr_width), ram_we (output, 1) and ram_q (input, data_width).
REQ-010 The block SHALL have the port init_done, output, 1 bit: high once the RAM clear has finished.

Function
REQ-011 The attached RAM SHALL write on a rising edge when ram_we=1 and SHALL present the word at the sampled address on ram_q after that edge when ram_we=0 (1-cycle read latency).
REQ-012 The FSM SHALL have four states: INIT, IDLE, READ_WAIT and RSP_HOLD.
REQ-013 In INIT: ram_we=1 and ram_data=0; ram_addr SHALL count 0 to depth-1, one word per cycle; wr_ready=rd_ready=0; after the word at address depth-1 is written, the FSM SHALL go to IDLE and init_done SHALL be set to 1 as a registered output.
REQ-014 In IDLE, wr_ready and rd_ready SHALL be asserted; a handshake is valid&&ready&&grant; ram_* SHALL be driven combinationally from the granted request in the same cycle.
REQ-015 Write handshake: ram_we=1, ram_addr=wr_addr, ram_data=wr_data; the RAM writes at that edge; the FSM stays in IDLE; a new write is possible every cycle.
REQ-016 Read handshake: ram_we=0, ram_addr=rd_addr; the FSM goes to READ_WAIT.
REQ-017 READ_WAIT (1 cycle): both readies=0; at the next edge ram_q SHALL be captured into rsp_data, rsp_valid SHALL be set to 1 and the FSM goes to RSP_HOLD; latency from read handshake edge to rsp_valid high is 2 edges.
REQ-018 RSP_HOLD: rsp_data SHALL be held stable until rsp_valid&&rsp_ready; rd_ready=0; writes SHALL still be accepted per REQ-015; on the response handshake rsp_valid SHALL clear and the FSM returns to IDLE.
REQ-019 When wr_valid and rd_valid are both high in IDLE, a 2-way round-robin SHALL arbitrate; write has priority on the first collision after INIT; priority SHALL toggle only when a collision is resolved.
REQ-020 Ordering SHALL be strictly handshake order: a read granted before a write to the same address returns the old data.
REQ-021 Addresses SHALL be used unmodified; address depth-1 is valid, and the INIT counter SHALL not wrap past depth-1.
REQ-022 When idle with no handshake, ram_we SHALL be 0 and ram_addr/ram_data SHALL hold their last values.

Reset
REQ-023 While rst_n=0, the block SHALL be in INIT at address 0 with init_done=0, rsp_valid=0, rsp_data=0, wr_ready=rd_ready=0 and the arbiter priority set to write.
REQ-024 Assertion of rst_n mid-operation SHALL abort any transfer and drop any pending response; after release the RAM clear SHALL restart from address 0.

Structure
REQ-025 The shared package ram_ctrl_pkg SHALL hold the state enum and the default parameter constants.
REQ-026 The round-robin grant logic SHALL be the sub-module ram_rr_arb; the single_port_ram SHALL be instantiated outside the block, by its parent or the bench.

Verification
REQ-027 Reset release: init_done SHALL rise 64 edges after rst_n goes high; a read at 40 SHALL return 00.
REQ-028 Back-to-back writes 10=AA, 20=55, 30=FF, then reads of 10, 20 and 30, SHALL return AA, 55 and FF in order, each with 2-edge latency.
REQ-029 Simultaneous wr(5,3C) and rd(5) immediately after INIT: the write SHALL be granted first and the read SHALL return 3C; on the next collision the read SHALL win.
REQ-030 With rsp_ready held low for 5 cycles: rsp_data SHALL stay stable and rd_ready SHALL be 0, while a write 7=99 is accepted; a read of 7 SHALL then return 99.
REQ-031 rst_n asserted during INIT at address 20 and again during READ_WAIT: all outputs SHALL take their reset values immediately, no response SHALL be produced, and the clear SHALL restart at address 0.
REQ-032 Write 63=81 and read back: the read SHALL return 81, and addresses 0 and 62 SHALL be unaffected.
